matrix_uart_sequencer: RTL
==========================

MATRIX_UART_SEQUENCER -- requirements
Module: matrix_uart_sequencer

Interface
REQ-001 SHALL have parameter N, default 3: maximum matrix dimension, 2..8.
REQ-002 SHALL have parameter DW, default 8: element width in bits, 8 or 16; EB = DW/8 bytes per element.
REQ-003 SHALL have parameter RW, default 16: result element width; RB = ceil(RW/8) bytes per result.
REQ-004 SHALL have parameter TIMEOUT, default 1024: compute watchdog limit in clk cycles.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 rx_data  input  8  received byte.
REQ-008 rx_valid  input  1  one-cycle strobe; rx_data is valid on that cycle.
REQ-009 tx_data  output  8  byte to transmit.
REQ-010 tx_start  output  1  one-cycle transmit request.
REQ-011 tx_busy  input  1  transmitter busy.
REQ-012 mult_start  output  1  compute request, level.
REQ-013 mult_done  input  1  compute complete.
REQ-014 a_flat, b_flat  output  N*N*DW each  operands, row-major; element (r,c) at index r*N+c.
REQ-015 result_flat  input  N*N*RW  products, same indexing.
REQ-016 size  output  4  active dimension.
REQ-017 state  output  3  FSM state code.
REQ-018 err  output  1  one-cycle error strobe.

Function
REQ-019 SHALL implement the FSM states IDLE=0, LOAD_A=1, LOAD_B=2, COMPUTE=3, SEND=4 and SEND_CHK=5.
REQ-020 In IDLE, an rx_valid byte SHALL be taken as the size byte: a value of 1..N latches size, zeroes all of a_flat/b_flat and moves to LOAD_A; 0 or >N pulses err and stays in IDLE.
REQ-021 In LOAD_A and LOAD_B, each rx_valid byte SHALL be written little-endian into the current element; after EB bytes the column advances; when the column reaches size it wraps to 0 and the row increments.
REQ-022 After size*size elements, LOAD_A SHALL go to LOAD_B and LOAD_B SHALL go to COMPUTE; the element counter clears on each transition.
REQ-023 Elements with row>=size or col>=size SHALL remain zero.
REQ-024 On entering COMPUTE, mult_start SHALL go high the next cycle and hold until mult_done is sampled high; operands SHALL stay stable throughout.
REQ-025 The watchdog SHALL count COMPUTE cycles; when it reaches TIMEOUT without mult_done, the block SHALL pulse err, drop mult_start and return to IDLE.
REQ-026 On mult_done, the block SHALL go to SEND and transmit results with index 0..size*size-1, each RB bytes LSB first, in row-major order over the active size.
REQ-027 Transmit handshake: tx_start SHALL be a one-cycle pulse with tx_data stable on that cycle and held until the next pulse.
REQ-028 After a pulse, the next pulse SHALL not occur earlier than 2 cycles later, and only on a cycle where tx_busy==0.
REQ-029 After the last byte, the block SHALL return to IDLE, or go to SEND_CHK when configured per REQ-035.
REQ-030 An rx_valid byte arriving in COMPUTE, SEND or SEND_CHK SHALL be discarded and SHALL pulse err.
REQ-031 If rx_valid and a watchdog expiry occur in the same cycle, a single err pulse SHALL be issued.

Reset
REQ-032 rst SHALL force: state=IDLE, size=0, tx_start=0, tx_data=0, mult_start=0, err=0, a_flat=0, b_flat=0, and all counters 0.
REQ-033 rst asserted mid-load, mid-compute or mid-send SHALL abort immediately; no further tx_start SHALL be issued and no partial state SHALL be retained.

Configuration
REQ-034 Macro MATSEQ_CHECKSUM_EN SHALL control a trailing checksum.
REQ-035 With MATSEQ_CHECKSUM_EN defined, the block SHALL keep a running XOR of every byte accepted in LOAD_A and LOAD_B, and SEND_CHK SHALL transmit that XOR as one extra byte under the REQ-027/REQ-028 handshake before IDLE.
REQ-036 Without MATSEQ_CHECKSUM_EN, SEND_CHK SHALL be unreachable and exactly size*size*RB bytes SHALL be sent.

Verification
REQ-037 N=3, DW=8, RW=16. Stimulus: size 02; A=01 02 03 04; B=05 06 07 08; model returns 19,22,43,50. Required tx: 13 00 16 00 2B 00 32 00; a_flat element 2 == 0.
REQ-038 Stimulus: size byte 00, then 04 (N=3). Required: two err pulses, state stays 0.
REQ-039 Stimulus: size 1 with mult_done held low. Required: err pulse exactly TIMEOUT cycles after COMPUTE entry; mult_start drops; state returns to 0.
REQ-040 Stimulus: tx_busy held high 50 cycles during SEND. Required: no tx_start while busy; no byte lost; minimum pulse spacing 2 cycles.
REQ-041 Stimulus: rst after 3 bytes of A. Required: all outputs at reset values; next size byte 01 is accepted normally.
REQ-042 With MATSEQ_CHECKSUM_EN, size 1, A=0x5A, B=0x0F. Required: the byte after the result bytes is 0x55.

Source files
------------

// File: rtl/matrix_uart_sequencer.sv
// matrix_uart_sequencer: receives a size byte and two matrices over a byte stream, runs an external multiplier, streams the products back.
// Define MATSEQ_CHECKSUM_EN to append an XOR checksum of every operand byte after the results.
module matrix_uart_sequencer #(
  parameter int N = 3,
  parameter int DW = 8,
  parameter int RW = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] rx_data,
  input  logic rx_valid,
  output logic [7:0] tx_data,
  output logic tx_start,
  input  logic tx_busy,
  output logic mult_start,
  input  logic mult_done,
  output logic [N*N*DW-1:0] a_flat,
  output logic [N*N*DW-1:0] b_flat,
  input  logic [N*N*RW-1:0] result_flat,
  output logic [3:0] size,
  output logic [2:0] state,
  output logic err
);
  localparam int EB = DW / 8;
  localparam int RB = (RW + 7) / 8;
  localparam int WW = $clog2(TIMEOUT + 1);
`ifdef MATSEQ_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, SEND, SEND_CHK} st_t;
  st_t cur, nxt;
  logic [3:0] row, col, bi;
  logic [WW-1:0] wd;
  logic [7:0] tx_q, chk, cur_byte;
  logic [RB*8-1:0] res;
  logic last_tx, size_ok, take, byte_end, mat_end, wd_exp, fire, bad_rx;
  int idx;
  assign state = cur;
  always_comb begin
    idx = int'(row) * N + int'(col);
    res = '0;
    res[RW-1:0] = result_flat[idx*RW +: RW];
    size_ok = rx_data != 8'd0 && int'(rx_data) <= N;
    take = rx_valid && (cur == LOAD_A || cur == LOAD_B);
    byte_end = int'(bi) == (cur == SEND ? RB : EB) - 1;
    mat_end = byte_end && row == size - 4'd1 && col == size - 4'd1;
    wd_exp = cur == COMPUTE && !mult_done && int'(wd) == TIMEOUT - 1;
    bad_rx = rx_valid && (cur == IDLE ? !size_ok : cur >= COMPUTE);
    cur_byte = cur == SEND_CHK ? chk : res[int'(bi)*8 +: 8];
    // last_tx enforces a one-cycle gap between pulses
    fire = (cur == SEND || cur == SEND_CHK) && !tx_busy && !last_tx;
    tx_start = fire;
    tx_data = fire ? cur_byte : tx_q;
    nxt = cur;
    case (cur)
      IDLE:     nxt = rx_valid && size_ok ? LOAD_A : IDLE;
      LOAD_A:   nxt = take && mat_end ? LOAD_B : LOAD_A;
      LOAD_B:   nxt = take && mat_end ? COMPUTE : LOAD_B;
      COMPUTE:  nxt = mult_done ? SEND : wd_exp ? IDLE : COMPUTE;
      SEND:     nxt = fire && mat_end ? (CHK ? SEND_CHK : IDLE) : SEND;
      SEND_CHK: nxt = fire ? IDLE : SEND_CHK;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= IDLE;
      size <= '0;
      a_flat <= '0;
      b_flat <= '0;
      row <= '0;
      col <= '0;
      bi <= '0;
      wd <= '0;
      tx_q <= '0;
      chk <= '0;
      last_tx <= 1'b0;
      mult_start <= 1'b0;
      err <= 1'b0;
    end else begin
      cur <= nxt;
      err <= bad_rx || wd_exp;
      last_tx <= fire;
      mult_start <= cur == COMPUTE && nxt == COMPUTE;
      wd <= cur == COMPUTE ? wd + 1'b1 : '0;
      if (fire) tx_q <= cur_byte;
      if (cur == IDLE && rx_valid && size_ok) begin
        size <= rx_data[3:0];
        a_flat <= '0;
        b_flat <= '0;
        chk <= '0;
      end
      if (take) begin
        if (cur == LOAD_A) a_flat[idx*DW + int'(bi)*8 +: 8] <= rx_data;
        else b_flat[idx*DW + int'(bi)*8 +: 8] <= rx_data;
        if (CHK) chk <= chk ^ rx_data;
      end
      // the same row/col/byte counters walk operands on load and results on send
      if (take || (fire && cur == SEND)) begin
        bi <= byte_end ? 4'd0 : bi + 4'd1;
        if (byte_end) begin
          col <= col == size - 4'd1 ? 4'd0 : col + 4'd1;
          if (col == size - 4'd1) row <= row == size - 4'd1 ? 4'd0 : row + 4'd1;
        end
      end
    end
endmodule
